// File: rtl/counter_mod_4m.sv
// counter_mod_4m: cascadable 4-mode up/down counter with runtime terminal
// count L (range 0..L), combinational carry/borrow-out and a registered
// wrap-event pulse.
// Optional feature macro: CNTR_SAT_EN (saturate at the limits instead of
// wrapping; wrap then stays low).
module counter_mod_4m #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       m,
   input  logic             Ci,
   input  logic [WIDTH-1:0] B,
   input  logic [WIDTH-1:0] L,
   output logic [WIDTH-1:0] Q,
   output logic             Co,
   output logic             wrap
);

`ifdef CNTR_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_UP   = 2'b01;
   localparam logic [1:0] MODE_DOWN = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   logic [WIDTH-1:0] q_next;
   logic             co_c;
   logic             wrap_next;

   // Next count and terminal-event decode from current Q, L and mode
   always_comb begin
      q_next    = Q;
      co_c      = 1'b0;
      wrap_next = 1'b0;
      case (m)
         MODE_HOLD: q_next = Q;
         MODE_UP: begin
            if (Ci) begin
               if (Q >= L) begin
                  co_c   = 1'b1;
                  q_next = SAT_EN ? L : '0;
               end else begin
                  q_next = Q + WIDTH'(1);
               end
            end
         end
         MODE_DOWN: begin
            if (Ci) begin
               if (Q == '0) begin
                  co_c   = 1'b1;
                  q_next = SAT_EN ? '0 : L;
               end else if (Q > L) begin
                  // L was lowered below the count: resync to the new top
                  q_next = L;
               end else begin
                  q_next = Q - WIDTH'(1);
               end
            end
         end
         MODE_LOAD: q_next = (B <= L) ? B : L;
         default:   q_next = Q;
      endcase
      wrap_next = SAT_EN ? 1'b0 : co_c;
   end

   // Carry/borrow-out is combinational so a cascade adds no latency
   assign Co = rst & co_c;

   // Count and wrap-pulse registers, asynchronously forced by reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         Q    <= WIDTH'(RESET_VAL);
         wrap <= 1'b0;
      end else begin
         Q    <= q_next;
         wrap <= wrap_next;
      end
   end

endmodule

// File: tb/tb_counter_mod_4m.sv
// Scoreboard bench for counter_mod_4m: driver pushes expectations from a
// behavioural model, an independent monitor pops and compares.
module tb_counter_mod_4m;

`ifdef CNTR_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif
   localparam int RV = 0;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] m   = 2'b00;
   logic       ci  = 1'b0;
   logic [7:0] b   = '0;
   logic [7:0] l   = '0;
   logic [7:0] q;
   logic       co;
   logic       wrap;

   // cascade pair (two 4-bit stages forming an 8-bit counter)
   logic [1:0] cm  = 2'b00;
   logic       cen = 1'b0;
   logic [7:0] cb  = '0;
   logic [3:0] clo, chi;
   logic       clo_co, chi_co, clo_w, chi_w;

   counter_mod_4m #(.WIDTH(8), .RESET_VAL(RV)) dut (
      .clk(clk), .rst(rst), .m(m), .Ci(ci), .B(b), .L(l),
      .Q(q), .Co(co), .wrap(wrap));

   counter_mod_4m #(.WIDTH(4), .RESET_VAL(0)) c_lo (
      .clk(clk), .rst(rst), .m(cm), .Ci(cen), .B(cb[3:0]), .L(4'hF),
      .Q(clo), .Co(clo_co), .wrap(clo_w));

   counter_mod_4m #(.WIDTH(4), .RESET_VAL(0)) c_hi (
      .clk(clk), .rst(rst), .m(cm), .Ci(clo_co), .B(cb[7:4]), .L(4'hF),
      .Q(chi), .Co(chi_co), .wrap(chi_w));

   always #5 clk = ~clk;

   typedef struct {
      int qc; logic co; logic wc; int qn; logic wn;
      int cqc; logic cco; int cqn; logic clw; logic chw;
   } item_t;

   item_t sb[$];
   int    checks = 0;
   int    errors = 0;

   // model state
   int   mq  = RV;
   logic mw  = 1'b0;
   int   cv  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step(input logic r, input logic [1:0] mm, input logic cii,
                       input logic [7:0] bb, input logic [7:0] ll,
                       input logic [1:0] cmm, input logic cci, input logic [7:0] cbb);
      item_t it;
      int    nq, ncv, lo, li, bi;
      logic  c, clc;
      @(negedge clk); #1;
      rst = r; m = mm; ci = cii; b = bb; l = ll; cm = cmm; cen = cci; cb = cbb;
      li = int'(ll); bi = int'(bb);
      if (!r) begin
         mq = RV; mw = 1'b0; cv = 0;
         it = '{qc: RV, co: 1'b0, wc: 1'b0, qn: RV, wn: 1'b0,
                cqc: 0, cco: 1'b0, cqn: 0, clw: 1'b0, chw: 1'b0};
      end else begin
         it.qc = mq; it.wc = mw; c = 1'b0; nq = mq;
         if (mm == 2'd1 && cii) begin
            if (mq >= li) begin c = 1'b1; nq = SAT ? li : 0; end
            else nq = mq + 1;
         end else if (mm == 2'd2 && cii) begin
            if (mq == 0) begin c = 1'b1; nq = SAT ? 0 : li; end
            else if (mq > li) nq = li;
            else nq = mq - 1;
         end else if (mm == 2'd3) begin
            nq = (bi <= li) ? bi : li;
         end
         it.co = c; it.qn = nq; it.wn = SAT ? 1'b0 : c;
         mq = nq; mw = it.wn;
         // cascade behaves as one 8-bit modulo-256 counter
         it.cqc = cv; lo = cv % 16; clc = 1'b0; it.cco = 1'b0; ncv = cv;
         if (cmm == 2'd1 && cci) begin
            clc = (lo == 15); it.cco = (cv == 255); ncv = (cv + 1) % 256;
         end else if (cmm == 2'd2 && cci) begin
            clc = (lo == 0); it.cco = (cv == 0); ncv = (cv + 255) % 256;
         end else if (cmm == 2'd3) begin
            ncv = int'(cbb);
         end
         it.cqn = ncv; it.clw = clc; it.chw = it.cco; cv = ncv;
      end
      sb.push_back(it);
   endtask

   // monitor: combinational/current values mid-cycle, registered values after the edge
   initial begin
      item_t it;
      forever begin
         @(negedge clk); #3;
         if (sb.size() != 0) begin
            it = sb.pop_front();
            chk("q_cur", 32'(q), 32'(it.qc));
            chk("co", 32'(co), 32'(it.co));
            chk("wrap_cur", 32'(wrap), 32'(it.wc));
`ifndef CNTR_SAT_EN
            chk("casc_q_cur", 32'({chi, clo}), 32'(it.cqc));
            chk("casc_co", 32'(chi_co), 32'(it.cco));
`endif
            @(posedge clk); #1;
            chk("q_next", 32'(q), 32'(it.qn));
            chk("wrap_next", 32'(wrap), 32'(it.wn));
`ifndef CNTR_SAT_EN
            chk("casc_q_next", 32'({chi, clo}), 32'(it.cqn));
            chk("casc_lo_wrap", 32'(clo_w), 32'(it.clw));
            chk("casc_hi_wrap", 32'(chi_w), 32'(it.chw));
`endif
         end
      end
   end

   // driver: directed scenarios then randomized traffic
   initial begin
      logic [7:0] cur_l;
      logic [1:0] rm, rcm;
      int         bound;
      // reset state
      step(0, 2'd0, 0, 8'd0, 8'd0, 2'd0, 0, 8'd0);
      // reset mid-count at 0x37
      step(1, 2'd3, 0, 8'h37, 8'hFF, 2'd0, 0, 8'd0);
      step(1, 2'd1, 1, 8'h00, 8'hFF, 2'd0, 0, 8'd0);
      step(0, 2'd1, 1, 8'h00, 8'hFF, 2'd0, 0, 8'd0);
      step(1, 2'd1, 1, 8'h00, 8'hFF, 2'd0, 0, 8'd0);
      step(1, 2'd1, 1, 8'h00, 8'hFF, 2'd0, 0, 8'd0);
      // up wrap at L=9
      step(1, 2'd3, 0, 8'd0, 8'd9, 2'd0, 0, 8'd0);
      for (int i = 0; i < 12; i++) step(1, 2'd1, 1, 8'd0, 8'd9, 2'd0, 0, 8'd0);
      // down wrap at L=5 from 2
      step(1, 2'd3, 0, 8'd2, 8'd5, 2'd0, 0, 8'd0);
      for (int i = 0; i < 5; i++) step(1, 2'd2, 1, 8'd0, 8'd5, 2'd0, 0, 8'd0);
      // load and clamp
      step(1, 2'd3, 1, 8'hB1, 8'd100, 2'd0, 0, 8'd0);
      step(1, 2'd3, 1, 8'd42, 8'd100, 2'd0, 0, 8'd0);
      // hold and disabled count at 7
      step(1, 2'd3, 0, 8'd7, 8'd100, 2'd0, 0, 8'd0);
      for (int i = 0; i < 3; i++) step(1, 2'd0, 1, 8'd0, 8'd100, 2'd0, 0, 8'd0);
      for (int i = 0; i < 3; i++) step(1, 2'd1, 0, 8'd0, 8'd100, 2'd0, 0, 8'd0);
      // L=0 divide-by-1, and L lowered below Q
      for (int i = 0; i < 2; i++) step(1, 2'd1, 1, 8'd0, 8'd0, 2'd0, 0, 8'd0);
      step(1, 2'd3, 0, 8'd50, 8'd100, 2'd0, 0, 8'd0);
      step(1, 2'd2, 1, 8'd0, 8'd10, 2'd0, 0, 8'd0);
      step(1, 2'd3, 0, 8'd50, 8'd100, 2'd0, 0, 8'd0);
      step(1, 2'd1, 1, 8'd0, 8'd10, 2'd0, 0, 8'd0);
      // full-range limit
      step(1, 2'd3, 0, 8'hFF, 8'hFF, 2'd0, 0, 8'd0);
      step(1, 2'd1, 1, 8'd0, 8'hFF, 2'd0, 0, 8'd0);
      // cascade carries
      step(1, 2'd0, 0, 8'd0, 8'd0, 2'd3, 0, 8'h1F);
      step(1, 2'd0, 0, 8'd0, 8'd0, 2'd1, 1, 8'h00);
      step(1, 2'd0, 0, 8'd0, 8'd0, 2'd3, 0, 8'hFF);
      step(1, 2'd0, 0, 8'd0, 8'd0, 2'd1, 1, 8'h00);
      step(1, 2'd0, 0, 8'd0, 8'd0, 2'd2, 1, 8'h00);
      // randomized traffic
      cur_l = 8'd7;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 7) == 0)
            cur_l = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                : 8'($urandom_range(0, 15));
         rm  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         rcm = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         step(($urandom_range(0, 39) != 0), rm, 1'($urandom_range(0, 4) != 0),
              8'($urandom_range(0, 255)), cur_l,
              rcm, 1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)));
      end
      bound = 0;
      while (sb.size() != 0 && bound < 20) begin
         @(negedge clk);
         bound++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
